// File: rtl/cmp_result_monitor.sv
// Windowed statistics collector for a G/L/E magnitude-comparator result stream.
// Counts outcomes over WIN valid samples and publishes a registered summary strobe.
module cmp_result_monitor #(
    parameter int WIN   = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             G,
    input  logic             L,
    input  logic             E,
    output logic             busy,
    output logic             out_valid,
    output logic [CNT_W-1:0] g_cnt,
    output logic [CNT_W-1:0] l_cnt,
    output logic [CNT_W-1:0] e_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] max_eq_run,
    output logic [1:0]       dom
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIN - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_g, r_l, r_e, r_err, r_idx, r_run, r_max;

    logic             w_accept, w_last;
    logic             w_is_g, w_is_l, w_is_e;
    logic [CNT_W-1:0] w_g, w_l, w_e, w_err, w_run, w_max;
    logic [1:0]       w_dom;

    // Post-update values including the sample on the bus, so the closing edge
    // can publish totals that already contain the WIN-th sample.
    // NOTE: every always_comb output gets a value on every path; otherwise a latch is inferred.
    always_comb begin
        w_accept = (r_state == S_ACCUM) && in_valid;
        w_is_g   = ({G, L, E} == 3'b100);
        w_is_l   = ({G, L, E} == 3'b010);
        w_is_e   = ({G, L, E} == 3'b001);
        w_g      = r_g + CNT_W'(w_is_g);
        w_l      = r_l + CNT_W'(w_is_l);
        w_e      = r_e + CNT_W'(w_is_e);
        w_err    = r_err + CNT_W'(!(w_is_g || w_is_l || w_is_e));
        w_run    = w_is_e ? (r_run + CNT_W'(1)) : '0;
        w_max    = (w_run > r_max) ? w_run : r_max;
        w_last   = w_accept && (r_idx == LAST_IDX);

        w_dom = 2'b00;
        if ((w_g > w_l) && (w_g > w_e)) begin
            w_dom = 2'b01;
        end else if ((w_l > w_g) && (w_l > w_e)) begin
            w_dom = 2'b10;
        end else if ((w_e > w_g) && (w_e > w_l)) begin
            w_dom = 2'b11;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_g        <= '0;
            r_l        <= '0;
            r_e        <= '0;
            r_err      <= '0;
            r_idx      <= '0;
            r_run      <= '0;
            r_max      <= '0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            g_cnt      <= '0;
            l_cnt      <= '0;
            e_cnt      <= '0;
            err_cnt    <= '0;
            max_eq_run <= '0;
            dom        <= 2'b00;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_g     <= '0;
                        r_l     <= '0;
                        r_e     <= '0;
                        r_err   <= '0;
                        r_idx   <= '0;
                        r_run   <= '0;
                        r_max   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_g   <= w_g;
                        r_l   <= w_l;
                        r_e   <= w_e;
                        r_err <= w_err;
                        r_run <= w_run;
                        r_max <= w_max;
                        r_idx <= r_idx + CNT_W'(1);
                        if (w_last) begin
                            g_cnt      <= w_g;
                            l_cnt      <= w_l;
                            e_cnt      <= w_e;
                            err_cnt    <= w_err;
                            max_eq_run <= w_max;
                            dom        <= w_dom;
                            out_valid  <= 1'b1;
                            r_state    <= S_REPORT;
                        end
                    end
                end
                S_REPORT: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_result_monitor.sv
// Scoreboard bench for cmp_result_monitor: stimulus pushes expected window summaries,
// an independent monitor pops and compares them on every out_valid strobe.
module tb_cmp_result_monitor;

    localparam int WIN   = 16;
    localparam int CNT_W = 5;

    typedef struct {
        int g;
        int l;
        int e;
        int err;
        int mx;
        int dom;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst, start, in_valid, G, L, E;
    logic             busy, out_valid;
    logic [CNT_W-1:0] g_cnt, l_cnt, e_cnt, err_cnt, max_eq_run;
    logic [1:0]       dom;

    exp_t exp_q[$];
    exp_t last_exp;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_ov  = 0;
    int   n_win = 0;

    cmp_result_monitor #(.WIN(WIN), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .G          (G),
        .L          (L),
        .E          (E),
        .busy       (busy),
        .out_valid  (out_valid),
        .g_cnt      (g_cnt),
        .l_cnt      (l_cnt),
        .e_cnt      (e_cnt),
        .err_cnt    (err_cnt),
        .max_eq_run (max_eq_run),
        .dom        (dom)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain tallies over the sample list, longest E streak, strict-winner rule.
    function automatic exp_t model(input logic [2:0] codes[$]);
        exp_t r;
        int   run;
        r   = '{0, 0, 0, 0, 0, 0};
        run = 0;
        foreach (codes[i]) begin
            if (codes[i] == 3'b100)      r.g++;
            else if (codes[i] == 3'b010) r.l++;
            else if (codes[i] == 3'b001) r.e++;
            else                         r.err++;
            run  = (codes[i] == 3'b001) ? run + 1 : 0;
            r.mx = (run > r.mx) ? run : r.mx;
        end
        if (r.g > r.l && r.g > r.e)      r.dom = 1;
        else if (r.l > r.g && r.l > r.e) r.dom = 2;
        else if (r.e > r.g && r.e > r.l) r.dom = 3;
        return r;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_g"}, int'(g_cnt), 0);
        check({tag, "_l"}, int'(l_cnt), 0);
        check({tag, "_e"}, int'(e_cnt), 0);
        check({tag, "_err"}, int'(err_cnt), 0);
        check({tag, "_max_run"}, int'(max_eq_run), 0);
        check({tag, "_dom"}, int'(dom), 0);
    endtask

    // Called at posedge+1; returns at posedge+1 with the DUT idle.
    task automatic run_window(input logic [2:0] codes[$], input int gap_pct, input bit poke);
        exp_q.push_back(model(codes));
        last_exp = model(codes);
        n_win++;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        foreach (codes[i]) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                in_valid  = 1'b0;
                {G, L, E} = 3'($urandom_range(7));
                start     = poke;
                @(posedge clk); #1;
                start = 1'b0;
            end
            in_valid  = 1'b1;
            {G, L, E} = codes[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        start    = poke;
        check("busy_in_report", int'(busy), 1);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_report", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        check("stay_idle", int'(busy), 0);
        check("hold_g", int'(g_cnt), last_exp.g);
        check("hold_dom", int'(dom), last_exp.dom);
    endtask

    task automatic abort_window(input int n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid  = 1'b1;
            {G, L, E} = 3'b001;
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Monitor: decoupled from stimulus, samples on the falling edge.
    initial begin : monitor
        bit   prev_ov;
        exp_t x;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                n_ov++;
                check("ov_single_cycle", int'(prev_ov), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    x = exp_q.pop_front();
                    check("g_cnt", int'(g_cnt), x.g);
                    check("l_cnt", int'(l_cnt), x.l);
                    check("e_cnt", int'(e_cnt), x.e);
                    check("err_cnt", int'(err_cnt), x.err);
                    check("max_eq_run", int'(max_eq_run), x.mx);
                    check("dom", int'(dom), x.dom);
                    check("busy_with_ov", int'(busy), 1);
                end
            end
            prev_ov = out_valid;
        end
    end

    initial begin : stimulus
        logic [2:0] q[$];
        int         r;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; {G, L, E} = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // All-equal window
        q = {};
        for (int i = 0; i < WIN; i++) q.push_back(3'b001);
        run_window(q, 0, 1'b0);

        // Mixed with gaps: E,E,E then 8 G, 5 L
        q = {3'b001, 3'b001, 3'b001};
        for (int i = 0; i < 8; i++) q.push_back(3'b100);
        for (int i = 0; i < 5; i++) q.push_back(3'b010);
        run_window(q, 30, 1'b0);

        // Malformed codes plus 12 L
        q = {3'b000, 3'b010, 3'b110, 3'b010, 3'b000, 3'b010, 3'b110};
        for (int i = 0; i < 9; i++) q.push_back(3'b010);
        run_window(q, 20, 1'b0);

        // Err sample between E's breaks the run
        q = {3'b001, 3'b001, 3'b111, 3'b001, 3'b001, 3'b001, 3'b011, 3'b001};
        for (int i = 0; i < 8; i++) q.push_back(3'b100);
        run_window(q, 10, 1'b0);

        // Tie with start pulsed throughout ACCUM and REPORT
        q = {};
        for (int i = 0; i < 8; i++) begin
            q.push_back(3'b100);
            q.push_back(3'b010);
        end
        run_window(q, 40, 1'b1);

        // Reset mid-window then a clean all-E window
        abort_window(7);
        q = {};
        for (int i = 0; i < WIN; i++) q.push_back(3'b001);
        run_window(q, 0, 1'b0);

        // Randomised windows
        for (int w = 0; w < 12; w++) begin
            q = {};
            for (int i = 0; i < WIN; i++) begin
                r = int'($urandom_range(9));
                if (r < 3)      q.push_back(3'b001);
                else if (r < 6) q.push_back(3'b100);
                else if (r < 8) q.push_back(3'b010);
                else            q.push_back(3'($urandom_range(7)));
            end
            run_window(q, 30, 1'($urandom_range(1)));
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("window_count", n_ov, n_win);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
